// File: rtl/ext_intr_ctrl_if.sv
// Request/handshake bundle between ext_intr_ctrl (slave) and the CPU-side logic (master).
// The intr_cnt signal and its CNT_W width exist only when INTR_CNT_EN is defined.
interface ext_intr_ctrl_if
`ifdef INTR_CNT_EN
    #(parameter int unsigned CNT_W = 16)
`endif
    ;
    logic ext_intr;
    logic ie_wr;
    logic ie_din;
    logic int_ack;
    logic eret;
    logic ovr_clr;
    logic irq;
    logic ie;
    logic pending;
    logic in_service;
    logic overrun;
`ifdef INTR_CNT_EN
    logic [CNT_W-1:0] intr_cnt;
`endif

    modport slave (
        input  ext_intr, ie_wr, ie_din, int_ack, eret, ovr_clr,
`ifdef INTR_CNT_EN
        output intr_cnt,
`endif
        output irq, ie, pending, in_service, overrun
    );

    modport master (
        output ext_intr, ie_wr, ie_din, int_ack, eret, ovr_clr,
`ifdef INTR_CNT_EN
        input  intr_cnt,
`endif
        input  irq, ie, pending, in_service, overrun
    );
endinterface

// File: rtl/ext_intr_ctrl.sv
// External interrupt controller: edge capture, irq/ack/eret handshake, post-eret holdoff.
// Define INTR_CNT_EN to add the CNT_W-bit accepted-interrupt counter (intr_cnt).
module ext_intr_ctrl #(
    parameter int unsigned HOLDOFF = 4
`ifdef INTR_CNT_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    ext_intr_ctrl_if.slave bus
);
    localparam int unsigned HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e        state_q;
    logic          in_q;
    logic          prev_q;
    logic          ie_q;
    logic          pending_q;
    logic          in_service_q;
    logic          overrun_q;
    logic          irq_q;
    logic [HW-1:0] holdoff_q;

    logic          rise;
    logic          ack_acc;
    logic          ie_d;

    // The level is registered once before edge detection, giving pending at n+1 and irq at n+2.
    assign rise    = in_q & ~prev_q;
    assign ack_acc = bus.int_ack & (state_q == ST_REQ);
    assign ie_d    = bus.ie_wr ? bus.ie_din : ie_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_q         <= 1'b1;
            prev_q       <= 1'b1;
            ie_q         <= 1'b0;
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
            overrun_q    <= 1'b0;
            irq_q        <= 1'b0;
            holdoff_q    <= '0;
        end else begin
            in_q   <= bus.ext_intr;
            prev_q <= in_q;
            ie_q   <= ie_d;

            // A fresh edge always survives a same-cycle ack.
            if (rise) begin
                pending_q <= 1'b1;
            end else if (ack_acc) begin
                pending_q <= 1'b0;
            end

            if (rise & pending_q & ~ack_acc) begin
                overrun_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end

            if (holdoff_q != '0) begin
                holdoff_q <= holdoff_q - 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pending_q && ie_q && (holdoff_q == '0)) begin
                        state_q <= ST_REQ;
                        irq_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.int_ack) begin
                        state_q      <= ST_SERVICE;
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!ie_d) begin
                        // Withdrawing the request leaves pending set for later.
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eret) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                        holdoff_q    <= HW'(HOLDOFF);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq        = irq_q;
    assign bus.ie         = ie_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.overrun    = overrun_q;

`ifdef INTR_CNT_EN
    logic [CNT_W-1:0] intr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            intr_cnt_q <= '0;
        end else if (ack_acc) begin
            intr_cnt_q <= intr_cnt_q + 1'b1;
        end
    end

    assign bus.intr_cnt = intr_cnt_q;
`endif
endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Directed + randomized bench for ext_intr_ctrl against a behavioural model of the controller.
// Counter checks are compiled in only when INTR_CNT_EN is defined.
module tb_ext_intr_ctrl;
    localparam int HOLDOFF = 4;
`ifdef INTR_CNT_EN
    localparam int CNT_W = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef INTR_CNT_EN
    ext_intr_ctrl_if #(.CNT_W(CNT_W)) bus ();
    ext_intr_ctrl #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    ext_intr_ctrl_if bus ();
    ext_intr_ctrl #(.HOLDOFF(HOLDOFF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_checks = 0;
    int n_pass = 0;

    // Behavioural model: two most recent ext_intr samples, request/service flags, holdoff timer.
    bit hist[$];
    bit m_pending, m_ie, m_irq, m_svc, m_ovr;
    int m_hold, m_cnt;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_update();
        bit rise, ack_ok, new_ie, old_pending, old_ie;
        int old_hold;
        if (!rst_n) begin
            hist = '{1'b1, 1'b1};
            m_pending = 0; m_ie = 0; m_irq = 0; m_svc = 0; m_ovr = 0;
            m_hold = 0; m_cnt = 0;
            return;
        end
        rise = hist[1] && !hist[0];
        void'(hist.pop_front());
        hist.push_back(bus.ext_intr);
        old_pending = m_pending;
        old_ie = m_ie;
        old_hold = m_hold;
        ack_ok = m_irq && bus.int_ack;
        new_ie = bus.ie_wr ? bus.ie_din : m_ie;

        m_ovr = (rise && old_pending && !ack_ok) ? 1'b1 : (bus.ovr_clr ? 1'b0 : m_ovr);
        m_pending = rise ? 1'b1 : (ack_ok ? 1'b0 : old_pending);
        m_ie = new_ie;
        m_hold = (old_hold > 0) ? old_hold - 1 : 0;

        if (m_irq) begin
            if (bus.int_ack) begin
                m_irq = 0;
                m_svc = 1;
`ifdef INTR_CNT_EN
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
`endif
            end else if (!new_ie) begin
                m_irq = 0;
            end
        end else if (m_svc) begin
            if (bus.eret) begin
                m_svc = 0;
                m_hold = HOLDOFF;
            end
        end else if (old_pending && old_ie && old_hold == 0) begin
            m_irq = 1;
        end
    endtask

    task automatic check_all();
        check_bit("irq", bus.irq, m_irq);
        check_bit("ie", bus.ie, m_ie);
        check_bit("pending", bus.pending, m_pending);
        check_bit("in_service", bus.in_service, m_svc);
        check_bit("overrun", bus.overrun, m_ovr);
`ifdef INTR_CNT_EN
        check_int("intr_cnt", int'(bus.intr_cnt), m_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        bus.ext_intr = 1'b1;
        bus.ie_wr = 1'b0;
        bus.ie_din = 1'b0;
        bus.int_ack = 1'b0;
        bus.eret = 1'b0;
        bus.ovr_clr = 1'b0;

        // 1: level held high through reset produces no request
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_bit("t1_irq", bus.irq, 1'b0);
        end
        check_bit("t1_pending", bus.pending, 1'b0);
        bus.ext_intr = 1'b0;
        step();

        // 2: enable, rise at n, pending at n+1, irq at n+2, ack at n+5
        bus.ie_wr = 1'b1; bus.ie_din = 1'b1;
        step();
        bus.ie_wr = 1'b0;
        step();
        bus.ext_intr = 1'b1;
        step();
        check_bit("t2_pending_n", bus.pending, 1'b0);
        step();
        check_bit("t2_pending_n1", bus.pending, 1'b1);
        check_bit("t2_irq_n1", bus.irq, 1'b0);
        step();
        check_bit("t2_irq_n2", bus.irq, 1'b1);
        step();
        step();
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check_bit("t2_irq_ack", bus.irq, 1'b0);
        check_bit("t2_svc_ack", bus.in_service, 1'b1);
        check_bit("t2_pending_ack", bus.pending, 1'b0);
        bus.ext_intr = 1'b0;
        step();

        // 3: two edges while in service, then holdoff after eret
        bus.ext_intr = 1'b1; step();
        bus.ext_intr = 1'b0; step(); step();
        bus.ext_intr = 1'b1; step();
        bus.ext_intr = 1'b0; step(); step();
        check_bit("t3_pending", bus.pending, 1'b1);
        check_bit("t3_overrun", bus.overrun, 1'b1);
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        for (int i = 1; i <= HOLDOFF + 1; i++) begin
            step();
            check_bit("t3_holdoff_irq", bus.irq, (i == HOLDOFF + 1) ? 1'b1 : 1'b0);
        end
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.eret = 1'b1; step(); bus.eret = 1'b0;
        bus.ovr_clr = 1'b1; step(); bus.ovr_clr = 1'b0;
        check_bit("t3_ovr_clr", bus.overrun, 1'b0);
        repeat (6) step();

        // 4: ie cleared in REQ withdraws irq, pending kept; re-enable restores irq
        bus.ext_intr = 1'b1; step();
        bus.ext_intr = 1'b0; step(); step();
        check_bit("t4_irq_up", bus.irq, 1'b1);
        bus.ie_wr = 1'b1; bus.ie_din = 1'b0;
        step();
        bus.ie_wr = 1'b0;
        check_bit("t4_irq_off", bus.irq, 1'b0);
        check_bit("t4_pending_kept", bus.pending, 1'b1);
        step(); step();
        check_bit("t4_irq_still_off", bus.irq, 1'b0);
        bus.ie_wr = 1'b1; bus.ie_din = 1'b1;
        step();
        bus.ie_wr = 1'b0;
        check_bit("t4_irq_wr1", bus.irq, 1'b0);
        step();
        check_bit("t4_irq_wr2", bus.irq, 1'b1);

        // 5: rise coincides with accepted ack
        bus.ext_intr = 1'b1; step();
        bus.ext_intr = 1'b0; bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check_bit("t5_svc", bus.in_service, 1'b1);
        check_bit("t5_pending", bus.pending, 1'b1);
        check_bit("t5_overrun", bus.overrun, 1'b0);
        bus.eret = 1'b1; step(); bus.eret = 1'b0;
        repeat (HOLDOFF + 1) step();
        check_bit("t5_queued_irq", bus.irq, 1'b1);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.eret = 1'b1; step(); bus.eret = 1'b0;
        repeat (6) step();

        // reset in the middle of a request drops everything
        bus.ext_intr = 1'b1; step();
        bus.ext_intr = 1'b0; step(); step();
        check_bit("rst_mid_irq_before", bus.irq, 1'b1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_bit("rst_mid_irq", bus.irq, 1'b0);
        check_bit("rst_mid_pending", bus.pending, 1'b0);
        check_bit("rst_mid_ie", bus.ie, 1'b0);
        bus.ie_wr = 1'b1; bus.ie_din = 1'b1; step(); bus.ie_wr = 1'b0;

        // 6: four accepted interrupts, then stray ack/eret in IDLE
        for (int k = 0; k < 4; k++) begin
            bus.ext_intr = 1'b1; step();
            bus.ext_intr = 1'b0; step(); step();
            bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
`ifdef INTR_CNT_EN
            check_int("t6_cnt", int'(bus.intr_cnt), (k + 1) % 4);
`endif
            bus.eret = 1'b1; step(); bus.eret = 1'b0;
            repeat (HOLDOFF + 1) step();
        end
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.eret = 1'b1; step(); bus.eret = 1'b0;
        check_bit("t6_stray_svc", bus.in_service, 1'b0);
        check_bit("t6_stray_irq", bus.irq, 1'b0);
`ifdef INTR_CNT_EN
        check_int("t6_stray_cnt", int'(bus.intr_cnt), 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.ext_intr = ~bus.ext_intr;
            bus.int_ack = ($urandom_range(0, 3) == 0);
            bus.eret    = ($urandom_range(0, 5) == 0);
            bus.ie_wr   = ($urandom_range(0, 15) == 0);
            bus.ie_din  = ($urandom_range(0, 3) != 0);
            bus.ovr_clr = ($urandom_range(0, 19) == 0);
            rst_n       = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
